// File: rtl/reservation_station_ooo.sv
// Out-of-order reservation station: any-slot allocation, broadcast wakeup with load bypass, oldest-ready select.
// Latency: a load with ready (or bypassed) operands reaches the issue register two edges after acceptance.
// Backpressure: issue_* holds while issue_ready is low; load_ready drops when every slot is occupied.
module reservation_station_ooo #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_WAKEUP  = 4,
    parameter int TAG_W       = 5,
    parameter int XLEN        = 32,
    parameter int PAYLOAD_W   = 64,
    localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [TAG_W-1:0]             load_tag,
    input  logic [PAYLOAD_W-1:0]         load_payload,
    input  logic                         load_src1_ready,
    input  logic                         load_src2_ready,
    input  logic [TAG_W-1:0]             load_src1_tag,
    input  logic [TAG_W-1:0]             load_src2_tag,
    input  logic [XLEN-1:0]              load_src1_value,
    input  logic [XLEN-1:0]              load_src2_value,
    input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
    input  logic [NUM_WAKEUP*TAG_W-1:0]  wakeup_tag,
    input  logic [NUM_WAKEUP*XLEN-1:0]   wakeup_value,
    input  logic                         flush,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [TAG_W-1:0]             issue_tag,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic [XLEN-1:0]              issue_src1_value,
    output logic [XLEN-1:0]              issue_src2_value,
    output logic [CNT_W-1:0]             count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_ENTRIES);

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } src_t;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [PAYLOAD_W-1:0] payload;
        src_t                 s1;
        src_t                 s2;
    } ent_t;

    logic [NUM_ENTRIES-1:0] vld_q;
    ent_t                   ent_q [NUM_ENTRIES];
    // age_q[i][j] set means entry j is older than entry i
    logic [NUM_ENTRIES-1:0] age_q [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] cand;
    logic [NUM_ENTRIES-1:0] sel;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   any_cand;
    logic                   alloc;
    logic                   issue_load;
    logic                   move;
    ent_t                   new_ent;

    // Descending scan so the lowest matching channel is the one that sticks.
    function automatic src_t capture(input src_t s,
                                     input logic [NUM_WAKEUP-1:0]       wv,
                                     input logic [NUM_WAKEUP*TAG_W-1:0] wt,
                                     input logic [NUM_WAKEUP*XLEN-1:0]  wd);
        src_t r;
        r = s;
        if (!s.rdy) begin
            for (int k = NUM_WAKEUP - 1; k >= 0; k--) begin
                if (wv[k] && (wt[k*TAG_W +: TAG_W] == s.tag)) begin
                    r.rdy = 1'b1;
                    r.val = wd[k*XLEN +: XLEN];
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        cand      = '0;
        sel       = '0;
        sel_idx   = '0;
        alloc_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            cand[i] = vld_q[i] && ent_q[i].s1.rdy && ent_q[i].s2.rdy;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel[i] = cand[i] && !(|(age_q[i] & cand));
            if (sel[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
        new_ent.tag     = load_tag;
        new_ent.payload = load_payload;
        new_ent.s1      = capture({load_src1_ready, load_src1_tag, load_src1_value},
                                  wakeup_valid, wakeup_tag, wakeup_value);
        new_ent.s2      = capture({load_src2_ready, load_src2_tag, load_src2_value},
                                  wakeup_valid, wakeup_tag, wakeup_value);
    end

    assign load_ready = (count != FULL_CNT);
    assign any_cand   = |cand;
    assign alloc      = load_valid && load_ready && !flush;
    assign issue_load = !issue_valid || issue_ready;
    assign move       = issue_load && any_cand;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q            <= '0;
            count            <= '0;
            issue_valid      <= 1'b0;
            issue_tag        <= '0;
            issue_payload    <= '0;
            issue_src1_value <= '0;
            issue_src2_value <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else if (flush) begin
            vld_q            <= '0;
            count            <= '0;
            issue_valid      <= 1'b0;
            issue_tag        <= '0;
            issue_payload    <= '0;
            issue_src1_value <= '0;
            issue_src2_value <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            count <= count + CNT_W'(alloc) - CNT_W'(move);
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (vld_q[i]) begin
                    ent_q[i].s1 <= capture(ent_q[i].s1, wakeup_valid, wakeup_tag, wakeup_value);
                    ent_q[i].s2 <= capture(ent_q[i].s2, wakeup_valid, wakeup_tag, wakeup_value);
                end
            end
            if (move) begin
                vld_q[sel_idx] <= 1'b0;
            end
            // Stale column bits left by freed slots are harmless and get cleared on reuse.
            if (alloc) begin
                vld_q[alloc_idx] <= 1'b1;
                ent_q[alloc_idx] <= new_ent;
                age_q[alloc_idx] <= vld_q;
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (IDX_W'(i) != alloc_idx) begin
                        age_q[i][alloc_idx] <= 1'b0;
                    end
                end
            end
            if (issue_load) begin
                issue_valid <= any_cand;
                if (any_cand) begin
                    issue_tag        <= ent_q[sel_idx].tag;
                    issue_payload    <= ent_q[sel_idx].payload;
                    issue_src1_value <= ent_q[sel_idx].s1.val;
                    issue_src2_value <= ent_q[sel_idx].s2.val;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station_ooo.sv
// Directed self-checking bench for reservation_station_ooo.
module tb_reservation_station_ooo;

    localparam int TW = 5;
    localparam int XL = 32;
    localparam int PW = 64;
    localparam int NW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic              load_ready;
    logic [TW-1:0]     load_tag;
    logic [PW-1:0]     load_payload;
    logic              load_src1_ready, load_src2_ready;
    logic [TW-1:0]     load_src1_tag, load_src2_tag;
    logic [XL-1:0]     load_src1_value, load_src2_value;
    logic [NW-1:0]     wakeup_valid;
    logic [NW*TW-1:0]  wakeup_tag;
    logic [NW*XL-1:0]  wakeup_value;
    logic              flush;
    logic              issue_valid;
    logic              issue_ready;
    logic [TW-1:0]     issue_tag;
    logic [PW-1:0]     issue_payload;
    logic [XL-1:0]     issue_src1_value, issue_src2_value;
    logic [3:0]        count;

    int checks = 0;
    int errors = 0;

    reservation_station_ooo dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_tag(load_tag), .load_payload(load_payload),
        .load_src1_ready(load_src1_ready), .load_src2_ready(load_src2_ready),
        .load_src1_tag(load_src1_tag), .load_src2_tag(load_src2_tag),
        .load_src1_value(load_src1_value), .load_src2_value(load_src2_value),
        .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
        .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_tag(issue_tag), .issue_payload(issue_payload),
        .issue_src1_value(issue_src1_value), .issue_src2_value(issue_src2_value),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        load_valid      = 1'b0;
        load_tag        = '0;
        load_payload    = '0;
        load_src1_ready = 1'b0;
        load_src2_ready = 1'b0;
        load_src1_tag   = '0;
        load_src2_tag   = '0;
        load_src1_value = '0;
        load_src2_value = '0;
        wakeup_valid    = '0;
        wakeup_tag      = '0;
        wakeup_value    = '0;
        flush           = 1'b0;
    endtask

    task automatic set_load(input logic [TW-1:0] t,
                            input logic r1, input logic [TW-1:0] t1, input logic [XL-1:0] v1,
                            input logic r2, input logic [TW-1:0] t2, input logic [XL-1:0] v2);
        load_valid      = 1'b1;
        load_tag        = t;
        load_payload    = {32'hA5A5_0000, 27'd0, t};
        load_src1_ready = r1;
        load_src1_tag   = t1;
        load_src1_value = v1;
        load_src2_ready = r2;
        load_src2_tag   = t2;
        load_src2_value = v2;
    endtask

    task automatic set_wake(input int ch, input logic [TW-1:0] t, input logic [XL-1:0] v);
        wakeup_valid[ch]           = 1'b1;
        wakeup_tag[ch*TW +: TW]    = t;
        wakeup_value[ch*XL +: XL]  = v;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        issue_ready = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
        checks++; if (issue_tag !== 5'd0 || issue_src1_value !== 32'd0 || issue_payload !== 64'd0)
            begin errors++; $display("FAIL reset_issue_data got tag %0d v1 %h pl %h want 0", issue_tag, issue_src1_value, issue_payload); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        issue_ready = 1'b1;
        set_load(5'd3, 1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        tick();
        idle_in();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d want 1", count); end
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 5'd3) begin errors++; $display("FAIL basic_issue got v%b tag %0d want v1 tag 3", issue_valid, issue_tag); end
        checks++; if (issue_src1_value !== 32'h11 || issue_src2_value !== 32'h22)
            begin errors++; $display("FAIL basic_values got %h/%h want 11/22", issue_src1_value, issue_src2_value); end
        checks++; if (issue_payload !== 64'hA5A5_0000_0000_0003) begin errors++; $display("FAIL basic_payload got %h want a5a5000000000003", issue_payload); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_count0 got %0d want 0", count); end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", issue_valid); end
    endtask

    task automatic test_wakeup;
        issue_ready = 1'b1;
        set_load(5'd5, 1'b0, 5'd9, 32'h0, 1'b1, 5'd9, 32'h55);
        tick();
        idle_in();
        tick();
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd1) begin errors++; $display("FAIL wake_waiting got v%b cnt %0d want v0 cnt 1", issue_valid, count); end
        set_wake(2, 5'd9, 32'hABCD);
        tick();
        idle_in();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_early got %b want 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 5'd5 || issue_src1_value !== 32'hABCD)
            begin errors++; $display("FAIL wake_issue got v%b tag %0d v1 %h want v1 tag 5 v1 abcd", issue_valid, issue_tag, issue_src1_value); end
        checks++; if (issue_src2_value !== 32'h55) begin errors++; $display("FAIL wake_ready_src_kept got %h want 55", issue_src2_value); end
        tick();
    endtask

    task automatic test_bypass;
        issue_ready = 1'b1;
        set_load(5'd5, 1'b0, 5'd9, 32'h0, 1'b1, 5'd0, 32'h66);
        set_wake(3, 5'd9, 32'h9999);
        set_wake(2, 5'd9, 32'hABCD);
        tick();
        idle_in();
        checks++; if (count !== 4'd1 || issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_count got cnt %0d v%b want cnt 1 v0", count, issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_src1_value !== 32'hABCD)
            begin errors++; $display("FAIL bypass_issue got v%b v1 %h want v1 abcd", issue_valid, issue_src1_value); end
        tick();
    endtask

    task automatic test_order;
        issue_ready = 1'b1;
        set_load(5'd1, 1'b0, 5'd11, 32'h0, 1'b1, 5'd0, 32'h2);
        tick();
        set_load(5'd2, 1'b0, 5'd12, 32'h0, 1'b1, 5'd0, 32'h2);
        tick();
        set_load(5'd3, 1'b0, 5'd13, 32'h0, 1'b1, 5'd0, 32'h2);
        tick();
        idle_in();
        set_wake(0, 5'd13, 32'h33);
        tick();
        idle_in();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_early got %b want 0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 5'd3 || issue_src1_value !== 32'h33)
            begin errors++; $display("FAIL order_first got v%b tag %0d v1 %h want tag 3 v1 33", issue_valid, issue_tag, issue_src1_value); end
        set_wake(0, 5'd11, 32'h31);
        set_wake(1, 5'd12, 32'h32);
        tick();
        idle_in();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_gap got %b want 0", issue_valid); end
        tick();
        checks++; if (issue_tag !== 5'd1 || issue_src1_value !== 32'h31) begin errors++; $display("FAIL order_second got tag %0d v1 %h want tag 1 v1 31", issue_tag, issue_src1_value); end
        tick();
        checks++; if (issue_tag !== 5'd2 || issue_src1_value !== 32'h32) begin errors++; $display("FAIL order_third got tag %0d v1 %h want tag 2 v1 32", issue_tag, issue_src1_value); end
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL order_empty got v%b cnt %0d want v0 cnt 0", issue_valid, count); end
    endtask

    task automatic test_back_to_back;
        issue_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_load(5'(40 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i + 8));
            tick();
            if (i > 0) begin
                checks++;
                if (issue_valid !== 1'b1 || issue_tag !== 5'(39 + i))
                    begin errors++; $display("FAIL b2b_issue_%0d got v%b tag %0d want tag %0d", i, issue_valid, issue_tag, 39 + i); end
            end
        end
        idle_in();
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 5'd43) begin errors++; $display("FAIL b2b_last got v%b tag %0d want tag 43", issue_valid, issue_tag); end
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL b2b_empty got v%b cnt %0d want v0 cnt 0", issue_valid, count); end
    endtask

    task automatic test_hold;
        issue_ready = 1'b0;
        set_load(5'd20, 1'b1, 5'd0, 32'h200, 1'b1, 5'd0, 32'h201);
        tick();
        set_load(5'd21, 1'b1, 5'd0, 32'h210, 1'b1, 5'd0, 32'h211);
        tick();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (issue_valid !== 1'b1 || issue_tag !== 5'd20 || issue_src1_value !== 32'h200 || count !== 4'd1)
                begin errors++; $display("FAIL hold_%0d got v%b tag %0d v1 %h cnt %0d want v1 tag 20 v1 200 cnt 1", i, issue_valid, issue_tag, issue_src1_value, count); end
        end
        issue_ready = 1'b1;
        tick();
        checks++; if (issue_tag !== 5'd21 || issue_src2_value !== 32'h211) begin errors++; $display("FAIL hold_release got tag %0d v2 %h want tag 21 v2 211", issue_tag, issue_src2_value); end
        tick();
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL hold_empty got %b want 0", issue_valid); end
    endtask

    task automatic test_full;
        issue_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_load(5'(10 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i + 100));
            tick();
        end
        checks++; if (count !== 4'd8 || load_ready !== 1'b0) begin errors++; $display("FAIL full_state got cnt %0d rdy %b want cnt 8 rdy 0", count, load_ready); end
        set_load(5'd19, 1'b1, 5'd0, 32'h19, 1'b1, 5'd0, 32'h19);
        tick();
        tick();
        checks++; if (count !== 4'd8 || issue_tag !== 5'd10) begin errors++; $display("FAIL full_ignore got cnt %0d tag %0d want cnt 8 tag 10", count, issue_tag); end
        issue_ready = 1'b1;
        tick();
        checks++; if (load_ready !== 1'b1 || count !== 4'd7 || issue_tag !== 5'd11)
            begin errors++; $display("FAIL full_free got rdy %b cnt %0d tag %0d want rdy 1 cnt 7 tag 11", load_ready, count, issue_tag); end
        issue_ready = 1'b0;
        tick();
        idle_in();
        checks++; if (count !== 4'd8 || load_ready !== 1'b0) begin errors++; $display("FAIL full_refill got cnt %0d rdy %b want cnt 8 rdy 0", count, load_ready); end
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (issue_valid !== 1'b1 || issue_tag !== 5'(12 + i))
                begin errors++; $display("FAIL full_drain_%0d got v%b tag %0d want tag %0d", i, issue_valid, issue_tag, 12 + i); end
        end
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL full_empty got v%b cnt %0d want v0 cnt 0", issue_valid, count); end
    endtask

    task automatic test_flush;
        issue_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_load(5'(1 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i));
            tick();
        end
        checks++; if (count !== 4'd5 || issue_valid !== 1'b1 || issue_tag !== 5'd1)
            begin errors++; $display("FAIL flush_pre got cnt %0d v%b tag %0d want cnt 5 v1 tag 1", count, issue_valid, issue_tag); end
        set_load(5'd30, 1'b1, 5'd0, 32'h30, 1'b1, 5'd0, 32'h30);
        flush = 1'b1;
        tick();
        idle_in();
        checks++; if (count !== 4'd0 || issue_valid !== 1'b0 || load_ready !== 1'b1 || issue_tag !== 5'd0)
            begin errors++; $display("FAIL flush_clear got cnt %0d v%b rdy %b tag %0d want cnt 0 v0 rdy 1 tag 0", count, issue_valid, load_ready, issue_tag); end
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped_%0d got v%b tag %0d want v0", i, issue_valid, issue_tag); end
        end
        set_load(5'd7, 1'b1, 5'd0, 32'h70, 1'b1, 5'd0, 32'h71);
        tick();
        idle_in();
        tick();
        checks++; if (issue_valid !== 1'b1 || issue_tag !== 5'd7) begin errors++; $display("FAIL flush_after got v%b tag %0d want v1 tag 7", issue_valid, issue_tag); end
        tick();
    endtask

    task automatic test_async_reset;
        issue_ready = 1'b0;
        set_load(5'd9, 1'b1, 5'd0, 32'h9, 1'b1, 5'd0, 32'h9);
        tick();
        set_load(5'd10, 1'b1, 5'd0, 32'hA, 1'b1, 5'd0, 32'hA);
        tick();
        idle_in();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (count !== 4'd0 || issue_valid !== 1'b0 || load_ready !== 1'b1)
            begin errors++; $display("FAIL async_reset got cnt %0d v%b rdy %b want cnt 0 v0 rdy 1", count, issue_valid, load_ready); end
        reset = 1'b0;
        tick();
        checks++; if (issue_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL async_after got v%b cnt %0d want v0 cnt 0", issue_valid, count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_order();
        test_back_to_back();
        test_hold();
        test_full();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
